// File: rtl/bk_serial_add.sv
// Multi-cycle WIDTH-bit adder: one 8-bit Brent-Kung slice reused LSB chunk first.
// Define BK_SERIAL_ADD_OVF_EN to add the signed-overflow output ovf.

module bk_add8 (
    input  logic [7:0] a_i,
    input  logic [7:0] b_i,
    input  logic       cin_i,
    output logic [7:0] sum_o,
    output logic       cout_o
`ifdef BK_SERIAL_ADD_OVF_EN
    ,
    output logic       c7_o
`endif
);
    logic [7:0] p;
    logic [7:0] g;
    logic [8:0] c;

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_pg
            assign p[gi] = a_i[gi] ^ b_i[gi];
            assign g[gi] = a_i[gi] & b_i[gi];
        end
    endgenerate

    // cin folds into bit 0's generate so every group is anchored at bit 0
    logic gg0;
    logic g1_0, g3_2, p3_2, g5_4, p5_4, g7_6, p7_6;
    logic g3_0, g7_4, p7_4, g7_0;
    logic g2_0, g4_0, g5_0, g6_0;

    always_comb begin
        gg0  = g[0] | (p[0] & cin_i);
        // up-sweep
        g1_0 = g[1] | (p[1] & gg0);
        g3_2 = g[3] | (p[3] & g[2]);
        p3_2 = p[3] & p[2];
        g5_4 = g[5] | (p[5] & g[4]);
        p5_4 = p[5] & p[4];
        g7_6 = g[7] | (p[7] & g[6]);
        p7_6 = p[7] & p[6];
        g3_0 = g3_2 | (p3_2 & g1_0);
        g7_4 = g7_6 | (p7_6 & g5_4);
        p7_4 = p7_6 & p5_4;
        g7_0 = g7_4 | (p7_4 & g3_0);
        // down-sweep fills in the remaining prefixes
        g5_0 = g5_4 | (p5_4 & g3_0);
        g2_0 = g[2] | (p[2] & g1_0);
        g4_0 = g[4] | (p[4] & g3_0);
        g6_0 = g[6] | (p[6] & g5_0);
    end

    assign c = {g7_0, g6_0, g5_0, g4_0, g3_0, g2_0, g1_0, gg0, cin_i};

    generate
        for (gi = 0; gi < 8; gi++) begin : g_sum
            assign sum_o[gi] = p[gi] ^ c[gi];
        end
    endgenerate

    assign cout_o = c[8];
`ifdef BK_SERIAL_ADD_OVF_EN
    assign c7_o = c[7];
`endif
endmodule

module bk_serial_add #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef BK_SERIAL_ADD_OVF_EN
    ,
    output logic             ovf
`endif
);
    localparam int NCHUNK = WIDTH / 8;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [IDXW-1:0]  idx_q;
    logic [IDXW-1:0]  idx_d;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] sum_q;
    logic             carry_q;
    logic             cout_q;
    logic             in_ready_q;
    logic             out_valid_q;

    logic [7:0]       a_chunk;
    logic [7:0]       b_chunk;
    logic [7:0]       slice_sum;
    logic             slice_cout;
`ifdef BK_SERIAL_ADD_OVF_EN
    logic             slice_c7;
    logic             ovf_q;
`endif

    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            if (idx_q == IDXW'(i)) begin
                a_chunk = a_q[8*i +: 8];
                b_chunk = b_q[8*i +: 8];
            end
        end
    end

    assign idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDXW'(1);

    bk_add8 u_slice (
        .a_i    (a_chunk),
        .b_i    (b_chunk),
        .cin_i  (carry_q),
        .sum_o  (slice_sum),
        .cout_o (slice_cout)
`ifdef BK_SERIAL_ADD_OVF_EN
        ,
        .c7_o   (slice_c7)
`endif
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            cout_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
`ifdef BK_SERIAL_ADD_OVF_EN
            ovf_q       <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid && in_ready_q) begin
                        a_q        <= a;
                        b_q        <= b;
                        carry_q    <= cin;
                        idx_q      <= '0;
                        in_ready_q <= 1'b0;
                        state_q    <= BUSY;
                    end
                end
                BUSY: begin
                    // sum is overwritten chunk by chunk; upper chunks keep the previous result meanwhile
                    for (int i = 0; i < NCHUNK; i++) begin
                        if (idx_q == IDXW'(i)) begin
                            sum_q[8*i +: 8] <= slice_sum;
                        end
                    end
                    carry_q <= slice_cout;
                    idx_q   <= idx_d;
                    if (idx_q == LAST_IDX) begin
                        cout_q      <= slice_cout;
`ifdef BK_SERIAL_ADD_OVF_EN
                        ovf_q       <= slice_c7 ^ slice_cout;
`endif
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    out_valid_q <= 1'b0;
                    in_ready_q  <= 1'b1;
                    state_q     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign sum       = sum_q;
    assign cout      = cout_q;
`ifdef BK_SERIAL_ADD_OVF_EN
    assign ovf       = ovf_q;
`endif
endmodule

// File: tb/tb_bk_serial_add.sv
// Scoreboard bench for bk_serial_add: directed vectors queued at issue, checked by a monitor.
module tb_bk_serial_add;
    localparam int WIDTH  = 32;
    localparam int NCHUNK = WIDTH / 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             in_valid = 1'b0;
    logic             cin = 1'b0;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef BK_SERIAL_ADD_OVF_EN
    logic             ovf;
`endif

    bk_serial_add #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout)
`ifdef BK_SERIAL_ADD_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    typedef struct packed {
        logic [WIDTH-1:0] s;
        logic             c;
        logic             o;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    int   last_acc = 0;
    logic prev_valid = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Monitor: a result is consumed on every negedge where valid and ready are both high
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (out_valid && !prev_valid)
                check("latency", 64'(cyc - last_acc), 64'(NCHUNK));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL spurious_result actual=sum %h required=no result", sum);
                end else begin
                    e = exp_q.pop_front();
                    $display("result sum=%h cout=%0b exp_sum=%h exp_cout=%0b", sum, cout, e.s, e.c);
                    check("sum", 64'(sum), 64'(e.s));
                    check("cout", 64'(cout), 64'(e.c));
`ifdef BK_SERIAL_ADD_OVF_EN
                    check("ovf", 64'(ovf), 64'(e.o));
`endif
                end
            end
        end
        prev_valid <= out_valid;
    end

    task automatic wait_accept();
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout actual=in_ready 0 required=1");
        end
        @(posedge clk);
        #1;
        last_acc = cyc;
        in_valid = 1'b0;
    endtask

    task automatic send(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv, input logic cv,
                        input logic [WIDTH-1:0] es, input logic ec, input logic eo);
        exp_q.push_back('{s: es, c: ec, o: eo});
        a = av;
        b = bv;
        cin = cv;
        in_valid = 1'b1;
        wait_accept();
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout actual=%0d pending required=0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset asserted mid-cycle takes effect without a clock edge
        #3 rst_n = 1'b0;
        #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_sum", 64'(sum), 64'd0);
        check("rst_cout", 64'(cout), 64'd0);
`ifdef BK_SERIAL_ADD_OVF_EN
        check("rst_ovf", 64'(ovf), 64'd0);
`endif
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("idle_hold", 64'({in_ready, out_valid, cout, sum}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
        end
        @(posedge clk);
        #1;

        send(32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0, 1'b0);
        wait_drain();
        send(32'hFFFFFFFF, 32'h00000000, 1'b1, 32'h00000000, 1'b1, 1'b0);
        wait_drain();
        send(32'h7FFFFFFF, 32'h00000001, 1'b0, 32'h80000000, 1'b0, 1'b1);
        send(32'h80000000, 32'h80000000, 1'b0, 32'h00000000, 1'b1, 1'b1);
        send(32'h000000FF, 32'h00000001, 1'b0, 32'h00000100, 1'b0, 1'b0);
        send(32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1, 1'b0);
        send(32'hAAAAAAAA, 32'h55555555, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0);
        wait_drain();

        // Backpressure: result held while a second request waits
        out_ready = 1'b0;
        send(32'h0000FFFF, 32'h00000001, 1'b0, 32'h00010000, 1'b0, 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin
                @(negedge clk);
                n++;
            end
        end
        exp_q.push_back('{s: 32'h7FFFFFFF, c: 1'b1, o: 1'b1});
        a = 32'h80000000;
        b = 32'hFFFFFFFF;
        cin = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold", 64'({out_valid, in_ready, cout, sum}), 64'({1'b1, 1'b0, 1'b0, 32'h00010000}));
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        wait_accept();
        wait_drain();

        // Reset mid-BUSY after two chunks: operation abandoned
        a = 32'h12345678;
        b = 32'h11111111;
        cin = 1'b0;
        in_valid = 1'b1;
        wait_accept();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_state", 64'({in_ready, out_valid, cout, sum}), 64'({1'b1, 1'b0, 1'b0, 32'h0}));
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("midrst_no_valid", 64'(out_valid), 64'd0);
        end
        @(posedge clk);
        #1;
        send(32'h12345678, 32'h11111111, 1'b0, 32'h23456789, 1'b0, 1'b0);
        wait_drain();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/bk_serial_add.md
Name: bk_serial_add

Overview:
- Multi-cycle wide adder built on one instance of the team's 8-bit Brent-Kung adder slice.
- Accepts WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds one 8-bit chunk per clock, LSB chunk first, carrying the slice's cout into the next chunk.
- Presents the WIDTH-bit sum and final carry-out over a valid/ready handshake. Sits between the operand source (register file / datapath mux) and the result consumer.

Parameters:
- WIDTH, 32, operand/sum width in bits. Must be a multiple of 8 and at least 8.
- NCHUNK, WIDTH/8, number of 8-bit slices processed. Derived; never overridden.

Ports:
- clk  input  1  single clock, rising edge
- rst_n  input  1  reset, asynchronous and active-low
- in_valid  input  1  operand request
- in_ready  output  1  block can accept operands
- a  input  WIDTH  operand A
- b  input  WIDTH  operand B
- cin  input  1  carry-in to bit 0
- out_valid  output  1  result available
- out_ready  input  1  consumer accepts result
- sum  output  WIDTH  a + b + cin, mod 2^WIDTH
- cout  output  1  carry out of bit WIDTH-1

Behaviour:
- Reset (rst_n low, async): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0, chunk index=0, carry reg=0, operand regs=0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1, out_valid=0.
  - When in_valid & in_ready at an edge: latch a, b into operand regs; carry reg<=cin; idx<=0; state<=BUSY.
  - Inputs are ignored once latched, so the source may change them freely afterwards.
- BUSY:
  - in_ready=0, out_valid=0.
  - Each cycle, the slice computes on a[8*idx+7:8*idx], b[8*idx+7:8*idx] with carry-in = carry reg.
  - At the edge: sum[8*idx+7:8*idx]<=slice sum; carry reg<=slice cout; idx<=idx+1.
  - When idx==NCHUNK-1: cout<=slice cout, state<=DONE, idx wraps to 0.
  - Exactly NCHUNK cycles are spent in BUSY.
- DONE:
  - out_valid=1, in_ready=0.
  - sum and cout are held stable until out_ready is sampled high.
  - On out_valid & out_ready: state<=IDLE.
  - sum/cout keep their values until the next result overwrites them chunk by chunk.
- Latency: with the accept at edge N, out_valid is high in the cycle following edge N+NCHUNK. Throughput is one op per NCHUNK+2 cycles with out_ready held high.
- No overlap: a new operand is never accepted while BUSY or DONE.
- in_valid while not ready: the request waits. The source must hold in_valid and data until the handshake.
- out_ready high while out_valid low: no effect.
- WIDTH=8: single BUSY cycle; behaviour otherwise identical.
- Reset mid-operation (BUSY or DONE): the operation is abandoned immediately. No out_valid pulse is produced for it, and all state returns to reset values.
- Arithmetic: pure unsigned modular sum. Carry chains exactly as one WIDTH-bit adder would, including the full-propagate case (all p=1) across every chunk.

Optional Feature:
- Macro: BK_SERIAL_ADD_OVF_EN.
- Defined:
  - Adds output port ovf (1 bit) = signed two's-complement overflow of a + b + cin.
  - Computed as carry into the MSB XOR carry out of the MSB.
  - Captured at the last BUSY cycle alongside cout, reset to 0, held in DONE like sum.
- Undefined: port ovf does not exist and no extra logic is generated. All other behaviour is identical.

Test Plan:
1. Reset then idle, WIDTH=32: rst_n low mid-cycle -> in_ready=1, out_valid=0, sum=0, cout=0 immediately without clock. Release; no in_valid -> outputs unchanged for 10 cycles.
2. Simple add: a=0x00000005, b=0x00000003, cin=0 -> out_valid exactly 4 cycles after the accept-edge state, sum=0x00000008, cout=0.
3. Full carry ripple across all chunks: a=0xFFFFFFFF, b=0x00000000, cin=1 -> sum=0x00000000, cout=1. With OVF_EN: ovf=0.
4. Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0. With OVF_EN: ovf=1. Second op a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
5. Backpressure: result ready with out_ready=0 for 5 cycles -> out_valid stays 1, sum/cout stable, in_ready=0, and a pending in_valid is not accepted. out_ready=1 -> IDLE next cycle, then the pending op is accepted.
6. Reset mid-BUSY: assert rst_n low after 2 chunks of a=0x12345678, b=0x11111111 -> no out_valid pulse, outputs reset. Next op a=0x12345678, b=0x11111111, cin=0 -> sum=0x23456789, cout=0.
